// File: rtl/std_pkg.sv
// -----------------------------------------------------------------------------
// std_pkg
// Shared definitions for the standard flow-control blocks.
//   std_skid_state_e : skid buffer state (EMPTY / BUSY / FULL), 2-bit encoding
//   STD_SKID_OCC_W   : width of the skid buffer occupancy count
// -----------------------------------------------------------------------------
package std_pkg;

   localparam int STD_SKID_OCC_W = 2;

   typedef enum logic [1:0] {
      STD_SKID_EMPTY = 2'd0,
      STD_SKID_BUSY  = 2'd1,
      STD_SKID_FULL  = 2'd2
   } std_skid_state_e;

endpackage

// File: rtl/std_skid_buffer.sv
// -----------------------------------------------------------------------------
// std_skid_buffer
// Two-entry register slice for a valid/ready stream. Every output (valid,
// data, upstream ready, occupancy) comes straight from a flop, so no path
// runs combinationally from either port to the other.
//
// Handshake: a beat moves on a port when its valid and ready are both high
// at a rising edge of clk; valid may rise while ready is low and the beat
// is simply not taken until ready is seen high.
//
// Parameters:
//   WIDTH         payload width in bits (default 32)
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   valid_input   upstream payload present
//   ready_input   buffer accepts payload (registered)
//   data_input    upstream payload
//   valid_output  downstream payload present (registered)
//   ready_output  downstream accepts payload
//   data_output   downstream payload (registered)
//   occupancy     beats held, 0..2 (registered); also the FSM state view
//
// Build option:
//   STD_SKID_BUFFER_ASSERT_EN  compiles in simulation-only protocol
//                              assertions; synthesized logic is unchanged.
// -----------------------------------------------------------------------------
module std_skid_buffer
   import std_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid_input,
   output logic                      ready_input,
   input  logic [WIDTH-1:0]          data_input,
   output logic                      valid_output,
   input  logic                      ready_output,
   output logic [WIDTH-1:0]          data_output,
   output logic [STD_SKID_OCC_W-1:0] occupancy
);

   std_skid_state_e           state_q, state_d;
   logic [WIDTH-1:0]          data_out_q, data_out_d;
   logic [WIDTH-1:0]          skid_q, skid_d;
   logic                      valid_out_q, valid_out_d;
   logic                      ready_in_q, ready_in_d;
   logic [STD_SKID_OCC_W-1:0] occ_q, occ_d;
   logic                      in_xfer, out_xfer;

   always_comb begin
      in_xfer    = valid_input & ready_in_q;
      out_xfer   = valid_out_q & ready_output;
      state_d    = state_q;
      data_out_d = data_out_q;
      skid_d     = skid_q;

      case (state_q)
         STD_SKID_EMPTY: begin
            if (in_xfer) begin
               state_d    = STD_SKID_BUSY;
               data_out_d = data_input;
            end
         end
         STD_SKID_BUSY: begin
            if (in_xfer && out_xfer) begin
               data_out_d = data_input;
            end else if (in_xfer) begin
               // Downstream stalled: park the new beat behind the held one.
               state_d = STD_SKID_FULL;
               skid_d  = data_input;
            end else if (out_xfer) begin
               state_d = STD_SKID_EMPTY;
            end
         end
         STD_SKID_FULL: begin
            // ready_input is low here, so only the drain side can move.
            if (out_xfer) begin
               state_d    = STD_SKID_BUSY;
               data_out_d = skid_q;
            end
         end
         default: begin
            state_d = STD_SKID_EMPTY;
         end
      endcase

      // Outputs are decoded from the next state and then registered.
      valid_out_d = (state_d != STD_SKID_EMPTY);
      ready_in_d  = (state_d != STD_SKID_FULL);
      case (state_d)
         STD_SKID_BUSY: occ_d = 2'd1;
         STD_SKID_FULL: occ_d = 2'd2;
         default:       occ_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= STD_SKID_EMPTY;
         data_out_q  <= '0;
         skid_q      <= '0;
         valid_out_q <= 1'b0;
         ready_in_q  <= 1'b0;
         occ_q       <= '0;
      end else begin
         state_q     <= state_d;
         data_out_q  <= data_out_d;
         skid_q      <= skid_d;
         valid_out_q <= valid_out_d;
         ready_in_q  <= ready_in_d;
         occ_q       <= occ_d;
      end
   end

   assign ready_input  = ready_in_q;
   assign valid_output = valid_out_q;
   assign data_output  = data_out_q;
   assign occupancy    = occ_q;

`ifdef STD_SKID_BUFFER_ASSERT_EN
   // Upstream must hold an offered beat until it is taken.
   a_up_hold: assert property (@(posedge clk) disable iff (rst)
      (valid_input && !ready_input) |=> (valid_input && $stable(data_input)));

   a_occ_range: assert property (@(posedge clk) disable iff (rst)
      occupancy != 2'd3);

   // Right after reset release both are low for one cycle by construction.
   a_not_stuck: assert property (@(posedge clk) disable iff (rst)
      !$past(rst) |-> (ready_input || valid_output));

   a_down_stable: assert property (@(posedge clk) disable iff (rst)
      (valid_output && !ready_output) |=> $stable(data_output));
`else
`endif

endmodule

// File: doc/std_skid_buffer.md
# std_skid_buffer

Receiver-side register slice for the valid/ready stream protocol used by the standard flow-control logic. It terminates an upstream stream whose `ready` may be combinational and re-drives it downstream with fully registered `valid_output`, `data_output` and `ready_input`. A two-entry skid store sustains one transfer per cycle while breaking every combinational path between the two ports. It is placed at pipeline-stage and module boundaries where timing closure needs registered handshakes.

## Interface
- `WIDTH`, default 32: payload width in bits.
- `clk`  input  1  single clock; all state changes on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `valid_input`  input  1  upstream payload present.
- `ready_input`  output  1  buffer accepts payload this cycle; flop output.
- `data_input`  input  WIDTH  upstream payload.
- `valid_output`  output  1  downstream payload present; flop output.
- `ready_output`  input  1  downstream accepts payload.
- `data_output`  output  WIDTH  downstream payload; flop output.
- `occupancy`  output  2  entries held, 0..2; flop output.

## Operation
- Transfer rule, both ports: a beat moves when valid and ready are both high at a rising edge.
- Storage: the output register drives `data_output`. The skid register holds a second beat.
- States:
  - EMPTY: 0 entries.
  - BUSY: 1 entry, in the output register.
  - FULL: 2 entries, output register plus skid register.
- Outputs derived from state:
  - `valid_output` = state ≠ EMPTY.
  - `ready_input` = state ≠ FULL.
  - `occupancy` = 0, 1 or 2.
  - All three are computed from next-state and registered; none depends combinationally on any input.
- Transitions, where in = input transfer and out = output transfer:
  - EMPTY, in → BUSY; output register ← data_input.
  - EMPTY, no in → EMPTY.
  - BUSY, in & out → BUSY; output register ← data_input.
  - BUSY, in & !out → FULL; skid register ← data_input.
  - BUSY, !in & out → EMPTY.
  - BUSY, neither → BUSY; hold.
  - FULL, out → BUSY; output register ← skid register. No input is possible because `ready_input` = 0.
  - FULL, no out → FULL; hold.
- Ordering: strict FIFO; beats are never dropped or duplicated.
- Data stability: `data_output` holds its value while `valid_output` && !`ready_output`.
- Skid register contents are don't-care outside FULL.

## Timing
- Reset values while `rst` is high: state EMPTY, `valid_output` 0, `ready_input` 0, `occupancy` 0, `data_output` 0, skid register 0.
- `ready_input` first rises at the first rising edge after `rst` deasserts.
- Latency: a beat accepted at edge N appears on `valid_output`/`data_output` after edge N (earliest consumption at edge N+1).
- Throughput: 1 beat/cycle sustained when `ready_output` stays high.
- Backpressure: `ready_output` low for one cycle fills the skid register. `ready_input` falls after that same edge.
- Recovery: the first `ready_output` in FULL restores `ready_input` after one edge.
- Reset mid-operation: all held beats are discarded. The buffer returns to the reset values on the next edge, regardless of handshakes in that cycle.
- `valid_input` asserted while `ready_input` is low is legal; the beat is simply not taken.

## Configuration
- `STD_SKID_BUFFER_ASSERT_EN` defined: simulation-only concurrent assertions are compiled in.
  - Upstream: `valid_input` && !`ready_input` implies `valid_input` and `data_input` are stable next cycle.
  - Internal: `occupancy` never equals 3; `ready_input` and `valid_output` are never both low outside reset.
  - Downstream: `data_output` is stable under stall.
- Undefined: no assertions; synthesized logic is identical either way.

## Structure
- Shared package `std_pkg`: the state enum (`STD_SKID_EMPTY`, `STD_SKID_BUSY`, `STD_SKID_FULL`, 2-bit encoding) and the occupancy width constant.
- Single flat module; no sub-module.

## Test plan
- Reset: hold `rst` 3 cycles with `valid_input` = 1 → `ready_input` = 0, `valid_output` = 0, `occupancy` = 0; `ready_input` = 1 on the first cycle after release.
- Streaming: send 0x1..0x10 back-to-back with `ready_output` = 1 → outputs 0x1..0x10 in order, 1 per cycle, first beat one cycle after acceptance, `occupancy` = 1 throughout.
- Single stall: stream 0xA, 0xB, 0xC with `ready_output` low for one cycle at beat 0xA → `occupancy` 2, `ready_input` 0 one cycle; output sequence 0xA, 0xB, 0xC with none lost.
- Full hold: fill with 0x55, 0x66 and hold `ready_output` = 0 for 10 cycles → `data_output` stays 0x55, `ready_input` stays 0; release → 0x55, then 0x66, then EMPTY.
- Random: random `valid_input`/`ready_output` for 10k cycles against a reference queue → exact order match; no output-port combinational dependence on the input ports (check via X-injection on the inputs).
- Reset while FULL → next cycle `valid_output` = 0, `occupancy` = 0; no stale beat emitted after release.
